// File: rtl/regfile_pkg.sv
`default_nettype none
// ============================================================================
// Module   : regfile_pkg
// Purpose  : Shared types and default parameters for the scoreboarded
//            register file (regfile_sb and its scoreboard sub-block).
// Revision : 1.0  initial release
// ============================================================================
package regfile_pkg;

    localparam int DATA_W_DEF = 32;
    localparam int ADDR_W_DEF = 5;
    localparam int NRD_DEF    = 2;

    // Sweep-clear controller states
    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        CLEAR = 1'b1
    } state_e;

endpackage : regfile_pkg
`default_nettype wire

// File: rtl/regfile_sb_score.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb_score
// Purpose  : Per-register busy scoreboard. Issue sets a bit, an accepted
//            write clears it (set wins on collision), a sweep start zeroes
//            all bits. Provides the per-read-port busy lookup.
// Revision : 1.0  initial release
// ============================================================================
module regfile_sb_score
    import regfile_pkg::*;
#(
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  clr_all,   // sweep starts: drop every busy bit
    input  logic                  blank,     // sweep running: no sets, busy reads 0
    input  logic                  set_vld,
    input  logic [ADDR_W-1:0]     set_addr,
    input  logic                  wr_vld,    // write already qualified by the top
    input  logic [ADDR_W-1:0]     wr_addr,
    input  logic [NRD*ADDR_W-1:0] raddr,
    input  logic [NRD-1:0]        fwd,       // port is being forwarded this cycle
    output logic [NRD-1:0]        rbusy
);

    localparam int DEPTH = 2 ** ADDR_W;

    logic [DEPTH-1:0] sb_q;
    logic [DEPTH-1:0] sb_d;

    // Next busy vector: clear-on-write first so a same-cycle issue wins
    always_comb begin
        sb_d = sb_q;
        if (clr_all) begin
            sb_d = '0;
        end else begin
            if (wr_vld) begin
                sb_d[wr_addr] = 1'b0;
            end
            if (set_vld && !blank) begin
                sb_d[set_addr] = 1'b1;
            end
        end
        sb_d[0] = 1'b0;   // register 0 is never busy
    end

    // Busy bit register
    always_ff @(posedge clk) begin
        if (rst) begin
            sb_q <= '0;
        end else begin
            sb_q <= sb_d;
        end
    end

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_busy
            logic [ADDR_W-1:0] ra;
            assign ra       = raddr[i*ADDR_W +: ADDR_W];
            assign rbusy[i] = !blank && !fwd[i] && sb_q[ra];
        end
    endgenerate

endmodule : regfile_sb_score
`default_nettype wire

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Purpose  : Multi-read-port register file with write-port scoreboard and a
//            sequential sweep clear (one register per cycle, 1..DEPTH-1).
//            Register 0 is hard zero and never busy.
// Config   : RF_BYPASS_EN - when defined, a same-cycle accepted write is
//            forwarded to any read port addressing it (data and busy=0).
// Revision : 1.0  initial release
// ============================================================================
module regfile_sb
    import regfile_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int ADDR_W = ADDR_W_DEF,
    parameter int NRD    = NRD_DEF
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  we,
    input  logic [ADDR_W-1:0]     waddr,
    input  logic [DATA_W-1:0]     wdata,
    input  logic [NRD*ADDR_W-1:0] raddr,
    output logic [NRD*DATA_W-1:0] rdata,
    output logic [NRD-1:0]        rbusy,
    input  logic                  iss_vld,
    input  logic [ADDR_W-1:0]     iss_rd,
    input  logic                  clr_req,
    output logic                  clr_busy
);

    localparam int                DEPTH     = 2 ** ADDR_W;
    localparam logic [ADDR_W-1:0] IDX_FIRST = ADDR_W'(1);
    localparam logic [ADDR_W-1:0] IDX_LAST  = {ADDR_W{1'b1}};

    state_e            state_q, state_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              clr_start;
    logic              wr_acc;
    logic [NRD-1:0]    fwd;

    logic [DATA_W-1:0] rf_q [DEPTH];
    logic [DATA_W-1:0] rf_d [DEPTH];

    assign clr_busy = (state_q == CLEAR);
    assign wr_acc   = we && (waddr != '0) && !clr_busy;

    // Sweep controller: IDLE waits for a request, CLEAR walks 1..DEPTH-1
    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        clr_start = 1'b0;
        case (state_q)
            IDLE: begin
                if (clr_req) begin
                    state_d   = CLEAR;
                    idx_d     = IDX_FIRST;
                    clr_start = 1'b1;
                end
            end
            CLEAR: begin
                if (idx_q == IDX_LAST) begin
                    state_d = IDLE;     // leave before the index would wrap
                end else begin
                    idx_d = idx_q + ADDR_W'(1);
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Next register contents: accepted write, then sweep zeroing
    always_comb begin
        for (int k = 0; k < DEPTH; k++) begin
            rf_d[k] = rf_q[k];
        end
        if (wr_acc) begin
            rf_d[waddr] = wdata;
        end
        if (state_q == CLEAR) begin
            rf_d[idx_q] = '0;
        end
        rf_d[0] = '0;
    end

    // State, index and storage registers; reset aborts any sweep
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            for (int k = 0; k < DEPTH; k++) begin
                rf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            for (int k = 0; k < DEPTH; k++) begin
                rf_q[k] <= rf_d[k];
            end
        end
    end

    generate
        for (genvar i = 0; i < NRD; i++) begin : g_rd
            logic [ADDR_W-1:0] ra;
            assign ra = raddr[i*ADDR_W +: ADDR_W];
`ifdef RF_BYPASS_EN
            assign fwd[i] = wr_acc && (ra == waddr);
            assign rdata[i*DATA_W +: DATA_W] = fwd[i] ? wdata : rf_q[ra];
`else
            assign fwd[i] = 1'b0;
            assign rdata[i*DATA_W +: DATA_W] = rf_q[ra];
`endif
        end
    endgenerate

    regfile_sb_score #(
        .ADDR_W (ADDR_W),
        .NRD    (NRD)
    ) u_score (
        .clk      (clk),
        .rst      (rst),
        .clr_all  (clr_start),
        .blank    (clr_busy),
        .set_vld  (iss_vld),
        .set_addr (iss_rd),
        .wr_vld   (wr_acc),
        .wr_addr  (waddr),
        .raddr    (raddr),
        .fwd      (fwd),
        .rbusy    (rbusy)
    );

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Purpose  : Scoreboard testbench for regfile_sb (default parameters).
//            Directed scenarios plus randomized traffic against a
//            behavioural model of the register file.
// Revision : 1.0  initial release
// ============================================================================
module tb_regfile_sb;

    localparam int DW    = 32;
    localparam int AW    = 5;
    localparam int NR    = 2;
    localparam int DEPTH = 32;

    logic              clk = 1'b0;
    logic              rst;
    logic              we;
    logic [AW-1:0]     waddr;
    logic [DW-1:0]     wdata;
    logic [NR*AW-1:0]  raddr;
    logic [NR*DW-1:0]  rdata;
    logic [NR-1:0]     rbusy;
    logic              iss_vld;
    logic [AW-1:0]     iss_rd;
    logic              clr_req;
    logic              clr_busy;

    always #5 clk = ~clk;

    regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .NRD(NR)) dut (
        .clk      (clk),
        .rst      (rst),
        .we       (we),
        .waddr    (waddr),
        .wdata    (wdata),
        .raddr    (raddr),
        .rdata    (rdata),
        .rbusy    (rbusy),
        .iss_vld  (iss_vld),
        .iss_rd   (iss_rd),
        .clr_req  (clr_req),
        .clr_busy (clr_busy)
    );

    typedef struct {
        logic [NR*DW-1:0] rd;
        logic [NR-1:0]    rb;
        logic             cb;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   total = 0;
    int   bad   = 0;

    // Behavioural model: contents, busy flags, sweep progress
    logic [DW-1:0] m_mem  [DEPTH];
    bit            m_busy [DEPTH];
    bit            m_sweep;
    int            m_pos;     // register zeroed at the end of this sweep cycle

    function automatic void model_reset();
        for (int k = 0; k < DEPTH; k++) begin
            m_mem[k]  = '0;
            m_busy[k] = 1'b0;
        end
        m_sweep = 1'b0;
        m_pos   = 0;
    endfunction

    // One clock: drive inputs, queue the expected outputs, advance the model
    task automatic cyc(input logic r, input logic w, input logic [AW-1:0] wa,
                       input logic [DW-1:0] wd, input logic [NR*AW-1:0] ra,
                       input logic iv, input logic [AW-1:0] ir, input logic cr);
        exp_t e;
        bit   acc;
        @(posedge clk);
        #1;
        rst = r; we = w; waddr = wa; wdata = wd; raddr = ra;
        iss_vld = iv; iss_rd = ir; clr_req = cr;

        acc  = w && (wa != 0) && !m_sweep;
        e.cb = m_sweep;
        for (int i = 0; i < NR; i++) begin
            int a;
            a = int'(ra[i*AW +: AW]);
            e.rd[i*DW +: DW] = m_mem[a];
            e.rb[i]          = m_busy[a] && !m_sweep;
`ifdef RF_BYPASS_EN
            if (acc && a == int'(wa)) begin
                e.rd[i*DW +: DW] = wd;
                e.rb[i]          = 1'b0;
            end
`endif
        end
        q.push_back(e);

        if (r) begin
            model_reset();
        end else if (m_sweep) begin
            m_mem[m_pos] = '0;
            if (m_pos == DEPTH - 1) m_sweep = 1'b0;
            else                    m_pos   = m_pos + 1;
        end else begin
            if (acc) m_mem[wa] = wd;
            if (cr) begin
                for (int k = 0; k < DEPTH; k++) m_busy[k] = 1'b0;
                m_sweep = 1'b1;
                m_pos   = 1;
            end else begin
                if (acc) m_busy[wa] = 1'b0;
                if (iv && ir != 0) m_busy[ir] = 1'b1;
            end
        end
    endtask

    task automatic idle(input logic [NR*AW-1:0] ra);
        cyc(1'b0, 1'b0, '0, '0, ra, 1'b0, '0, 1'b0);
    endtask

    function automatic logic [NR*AW-1:0] rpair(input int a0, input int a1);
        logic [NR*AW-1:0] v;
        v = '0;
        v[0 +: AW]  = AW'(a0);
        v[AW +: AW] = AW'(a1);
        return v;
    endfunction

    // Monitor: compare DUT outputs with the oldest queued expectation
    always @(negedge clk) begin
        if (q.size() > 0) begin
            mon_e = q.pop_front();
            total++;
            if (clr_busy !== mon_e.cb) begin
                bad++;
                $display("FAIL clr_busy got=%0b exp=%0b t=%0t", clr_busy, mon_e.cb, $time);
            end
            for (int i = 0; i < NR; i++) begin
                total++;
                if (rdata[i*DW +: DW] !== mon_e.rd[i*DW +: DW]) begin
                    bad++;
                    $display("FAIL rdata[%0d] addr=%0d got=%h exp=%h t=%0t", i,
                             raddr[i*AW +: AW], rdata[i*DW +: DW], mon_e.rd[i*DW +: DW], $time);
                end
                total++;
                if (rbusy[i] !== mon_e.rb[i]) begin
                    bad++;
                    $display("FAIL rbusy[%0d] addr=%0d got=%0b exp=%0b t=%0t", i,
                             raddr[i*AW +: AW], rbusy[i], mon_e.rb[i], $time);
                end
            end
        end
    end

    int busy_cnt;

    initial begin
        rst = 1'b1; we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
        iss_vld = 1'b0; iss_rd = '0; clr_req = 1'b0;
        repeat (2) @(posedge clk);
        model_reset();

        // Reset state, then write/read-back and write to register 0
        idle(rpair(5, 0));
        cyc(1'b0, 1'b1, 5'd5, 32'hDEADBEEF, rpair(5, 3), 1'b0, '0, 1'b0);
        idle(rpair(5, 0));
        cyc(1'b0, 1'b1, 5'd0, 32'hFFFFFFFF, rpair(0, 0), 1'b0, '0, 1'b0);
        idle(rpair(0, 5));

        // Same-cycle write/read on port 1, then next cycle
        cyc(1'b0, 1'b1, 5'd7, 32'h12345678, rpair(1, 7), 1'b0, '0, 1'b0);
        idle(rpair(7, 7));

        // Scoreboard: issue, clear by write, issue+write collision, r0 never busy
        cyc(1'b0, 1'b0, '0, '0, rpair(3, 3), 1'b1, 5'd3, 1'b0);
        idle(rpair(3, 4));
        cyc(1'b0, 1'b1, 5'd3, 32'hA5A5A5A5, rpair(3, 3), 1'b0, '0, 1'b0);
        idle(rpair(3, 0));
        cyc(1'b0, 1'b1, 5'd3, 32'h0BADF00D, rpair(3, 3), 1'b1, 5'd3, 1'b0);
        idle(rpair(3, 3));
        cyc(1'b0, 1'b0, '0, '0, rpair(0, 0), 1'b1, 5'd0, 1'b0);
        idle(rpair(0, 3));

        // Sweep clear: preload 1..31, pulse, count busy cycles, lose a write
        for (int k = 1; k < DEPTH; k++) begin
            cyc(1'b0, 1'b1, AW'(k), $urandom, rpair(k, DEPTH - k), 1'b1, AW'(k ^ 5), 1'b0);
        end
        cyc(1'b0, 1'b0, '0, '0, rpair(9, 4), 1'b0, '0, 1'b1);
        busy_cnt = 0;
        for (int c = 0; c < 36; c++) begin
            if (c == 5)
                cyc(1'b0, 1'b1, 5'd9, 32'hCAFEF00D, rpair(9, c), 1'b1, 5'd9, 1'b1);
            else
                idle(rpair(c % DEPTH, (c * 7) % DEPTH));
            #1;
            if (clr_busy === 1'b1) busy_cnt++;
        end
        total++;
        if (busy_cnt != DEPTH - 1) begin
            bad++;
            $display("FAIL sweep_len got=%0d exp=%0d", busy_cnt, DEPTH - 1);
        end
        for (int k = 0; k < DEPTH; k += 2) idle(rpair(k, k + 1));

        // Reset during the sweep
        for (int k = 1; k < DEPTH; k++) begin
            cyc(1'b0, 1'b1, AW'(k), $urandom, rpair(k, 1), 1'b0, '0, 1'b0);
        end
        cyc(1'b0, 1'b0, '0, '0, rpair(2, 20), 1'b1, 5'd2, 1'b1);
        for (int c = 1; c < 10; c++) idle(rpair(c, 20 + c));
        cyc(1'b1, 1'b1, 5'd12, 32'h11111111, rpair(12, 30), 1'b1, 5'd12, 1'b1);
        idle(rpair(12, 30));
        #1;
        total++;
        if (clr_busy !== 1'b0) begin
            bad++;
            $display("FAIL clr_busy_after_rst got=%0b exp=0", clr_busy);
        end
        for (int k = 0; k < DEPTH; k += 2) idle(rpair(k, k + 1));

        // Randomized traffic
        for (int n = 0; n < 3000; n++) begin
            cyc(($urandom_range(0, 299) == 0),
                ($urandom_range(0, 2) != 0), AW'($urandom), $urandom,
                NR*AW'($urandom), ($urandom_range(0, 1) == 1), AW'($urandom),
                ($urandom_range(0, 79) == 0));
        end

        repeat (3) @(posedge clk);
        total++;
        if (q.size() != 0) begin
            bad++;
            $display("FAIL drain got=%0d exp=0", q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
